mem_stage: RTL and testbench

- Memory-access stage of the 5-stage pipelined core; the receiving end of the EX-MEM valid/ack interface, and the EX-side of the MEM-WB interface.
- Non-memory instructions pass through in one cycle. Loads and stores run a request/grant/rvalid transaction on the data-memory port.
- Handles load sign/zero extension and store byte-lane steering, then presents a registered result to WB with the same valid/ack handshake.

---
 rtl/mem_stage_if.sv | 15 +
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request/grant/rvalid handshake.
// master = pipeline side issuing requests, slave = memory side.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: passes ALU results through, runs load/store transactions
// on the data-memory port and presents a registered result to WB.
module mem_stage (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        halt_i,
    input  logic        valid_i,
    output logic        ack_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] result_i,
    input  logic [31:0] rs2_i,
    input  logic        branch_i,
    input  logic        ack_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] data_o,
    output logic        branch_o,
    mem_stage_if.master dmem
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state_r;
    logic        valid_r, branch_r;
    logic [31:0] instr_r, pc_r, data_r;
    logic        req_r, req_we_r, req_branch_r, discard_r;
    logic [3:0]  req_be_r;
    logic [31:0] req_instr_r, req_pc_r, req_addr_r, req_wdata_r, req_data_r;

    logic        is_load_s, is_store_s, is_mem_s, out_free_s, accept_s;

    function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] rs2);
        case (funct3[1:0])
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign is_load_s  = (instr_i[6:0] == 7'b0000011);
    assign is_store_s = (instr_i[6:0] == 7'b0100011);
    assign is_mem_s   = is_load_s || is_store_s;
    assign out_free_s = !valid_r || ack_i;
    // Gated by rstn_i so EX never sees a handshake while the stage is held in reset.
    assign accept_s   = rstn_i && valid_i && (state_r == IDLE) && out_free_s && !flush_i;
    assign ack_o      = accept_s;

    assign valid_o  = flush_i ? 1'b0 : valid_r;
    assign branch_o = branch_r;
    assign instr_o  = instr_r;
    assign pc_o     = pc_r;
    assign data_o   = data_r;

    assign dmem.req   = req_r;
    assign dmem.we    = req_we_r;
    assign dmem.be    = req_be_r;
    assign dmem.addr  = {req_addr_r[31:2], 2'b00};
    assign dmem.wdata = req_wdata_r;

    // Memory transaction FSM and request register.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r      <= IDLE;
            req_r        <= 1'b0;
            req_we_r     <= 1'b0;
            req_branch_r <= 1'b0;
            discard_r    <= 1'b0;
            req_be_r     <= 4'd0;
            req_instr_r  <= 32'd0;
            req_pc_r     <= 32'd0;
            req_addr_r   <= 32'd0;
            req_wdata_r  <= 32'd0;
            req_data_r   <= 32'd0;
        end else if (!halt_i) begin
            case (state_r)
                IDLE: begin
                    if (accept_s && is_mem_s) begin
                        req_r        <= 1'b1;
                        req_we_r     <= is_store_s;
                        req_branch_r <= branch_i;
                        req_be_r     <= lane_be(instr_i[14:12], result_i[1:0]);
                        req_instr_r  <= instr_i;
                        req_pc_r     <= pc_i;
                        req_addr_r   <= result_i;
                        req_wdata_r  <= lane_wdata(instr_i[14:12], rs2_i);
                        req_data_r   <= result_i;
                        state_r      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem.gnt) begin
                        req_r <= 1'b0;
                        if (req_we_r) begin
                            state_r <= flush_i ? IDLE : DONE;
                        end else begin
                            // A granted load must still drain its rvalid even when flushed.
                            discard_r <= flush_i;
                            state_r   <= WAIT;
                        end
                    end else if (flush_i) begin
                        req_r   <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (dmem.rvalid) begin
                        if (discard_r || flush_i) begin
                            discard_r <= 1'b0;
                            state_r   <= IDLE;
                        end else begin
                            req_data_r <= load_ext(req_instr_r[14:12], req_addr_r[1:0], dmem.rdata);
                            state_r    <= DONE;
                        end
                    end else if (flush_i) begin
                        discard_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (flush_i || out_free_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Output register towards WB.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_r  <= 1'b0;
            branch_r <= 1'b0;
            instr_r  <= 32'd0;
            pc_r     <= 32'd0;
            data_r   <= 32'd0;
        end else if (!halt_i) begin
            if (flush_i) begin
                valid_r  <= 1'b0;
                branch_r <= 1'b0;
            end else if (accept_s && !is_mem_s) begin
                valid_r  <= 1'b1;
                branch_r <= branch_i;
                instr_r  <= instr_i;
                pc_r     <= pc_i;
                data_r   <= result_i;
            end else if ((state_r == DONE) && out_free_s) begin
                valid_r  <= 1'b1;
                branch_r <= req_branch_r;
                instr_r  <= req_instr_r;
                pc_r     <= req_pc_r;
                data_r   <= req_data_r;
            end else if (ack_i) begin
                valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized transactions
// against a behavioural model, and hand-written flush/stall/reset/halt sequences.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rstn_i, flush_i, halt_i, valid_i, ack_o, branch_i, ack_i, valid_o, branch_o;
    logic [31:0] instr_i, pc_i, result_i, rs2_i, instr_o, pc_o, data_o;
    logic        ld_busy;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] ADD = 32'h0020_81B3;
    localparam logic [31:0] LW  = 32'h0000_A103;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i), .halt_i(halt_i),
        .valid_i(valid_i), .ack_o(ack_o), .instr_i(instr_i), .pc_i(pc_i),
        .result_i(result_i), .rs2_i(rs2_i), .branch_i(branch_i), .ack_i(ack_i),
        .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .data_o(data_o),
        .branch_o(branch_o), .dmem(dmem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] result;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        br;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [12];

    // Protocol guard on the bench's own stimulus: no halt while a memory transaction is open.
    always @(negedge clk) begin
        if (rstn_i) begin
            assert (!(halt_i && (dmem_bus.req || ld_busy)))
            else $error("FAIL halt_in_txn: halt_i=%0b req=%0b busy=%0b required no halt", halt_i, dmem_bus.req, ld_busy);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t make_rand();
        vec_t        v;
        int          kind, off;
        logic [2:0]  f3;
        logic [31:0] b, h;
        kind        = int'($urandom_range(0, 2));
        v.result    = $urandom;
        v.rs2       = $urandom;
        v.rdata     = $urandom;
        v.br        = 1'($urandom_range(0, 1));
        v.gnt_dly   = int'($urandom_range(0, 3));
        v.rv_dly    = int'($urandom_range(1, 3));
        v.exp_be    = 4'd0;
        v.exp_wdata = 32'd0;
        off         = int'(v.result % 32'd4);
        if (kind == 0) begin
            v.instr    = {7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
            v.exp_data = v.result;
        end else if (kind == 1) begin
            case ($urandom_range(0, 4))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            v.instr = {12'd0, 5'd1, f3, 5'd2, 7'b0000011};
            b = (v.rdata >> (8 * off)) & 32'hFF;
            h = (v.rdata >> (16 * (off / 2))) & 32'hFFFF;
            case (f3)
                3'd0: v.exp_data = (b >= 32'd128) ? b - 32'd256 : b;
                3'd4: v.exp_data = b;
                3'd1: v.exp_data = (h >= 32'd32768) ? h - 32'd65536 : h;
                3'd5: v.exp_data = h;
                default: v.exp_data = v.rdata;
            endcase
            if (f3 == 3'd0 || f3 == 3'd4) v.exp_be = 4'(32'd1 << off);
            else if (f3 == 3'd2) v.exp_be = 4'b1111;
            else v.exp_be = (off >= 2) ? 4'b1100 : 4'b0011;
        end else begin
            f3 = 3'($urandom_range(0, 2));
            v.instr    = {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
            v.exp_data = v.result;
            case (f3)
                3'd0: begin v.exp_be = 4'(32'd1 << off); v.exp_wdata = (v.rs2 & 32'hFF) * 32'h0101_0101; end
                3'd1: begin v.exp_be = (off >= 2) ? 4'b1100 : 4'b0011; v.exp_wdata = (v.rs2 & 32'hFFFF) * 32'h0001_0001; end
                default: begin v.exp_be = 4'b1111; v.exp_wdata = v.rs2; end
            endcase
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input logic [31:0] pc, input string tag);
        logic is_ld, is_st;
        int   n;
        is_ld = (v.instr[6:0] == 7'b0000011);
        is_st = (v.instr[6:0] == 7'b0100011);
        @(negedge clk);
        valid_i = 1'b1; instr_i = v.instr; pc_i = pc; result_i = v.result;
        rs2_i = v.rs2; branch_i = v.br; ack_i = 1'b1;
        #1;
        n = 0;
        while (!ack_o && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, ".ack"}, 32'(ack_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        if (is_ld || is_st) begin
            n = 0;
            for (int k = 0; k <= v.gnt_dly; k++) begin
                if (k > 0) @(negedge clk);
                if (dmem_bus.req) n++;
                check({tag, ".addr"}, dmem_bus.addr, v.result - (v.result % 32'd4));
                check({tag, ".be"}, 32'(dmem_bus.be), 32'(v.exp_be));
                if (k == 0) begin
                    check({tag, ".we"}, 32'(dmem_bus.we), 32'(is_st));
                    if (is_st) check({tag, ".wdata"}, dmem_bus.wdata, v.exp_wdata);
                end
                dmem_bus.gnt = (k == v.gnt_dly);
            end
            check({tag, ".req_cycles"}, 32'(n), 32'(v.gnt_dly + 1));
            @(negedge clk);
            dmem_bus.gnt = 1'b0;
            check({tag, ".req_drop"}, 32'(dmem_bus.req), 32'd0);
            if (is_ld) begin
                ld_busy = 1'b1;
                for (int k = 1; k <= v.rv_dly; k++) begin
                    if (k > 1) @(negedge clk);
                    dmem_bus.rvalid = (k == v.rv_dly);
                    dmem_bus.rdata  = (k == v.rv_dly) ? v.rdata : ~v.rdata;
                end
                @(negedge clk);
                dmem_bus.rvalid = 1'b0;
                ld_busy = 1'b0;
            end
        end else begin
            check({tag, ".no_req"}, 32'(dmem_bus.req), 32'd0);
        end
        n = 0;
        while (!valid_o && n < 10) begin
            @(negedge clk); n++;
        end
        check({tag, ".latency"}, 32'(n), (is_ld || is_st) ? 32'd1 : 32'd0);
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        check({tag, ".data"}, data_o, v.exp_data);
        check({tag, ".instr"}, instr_o, v.instr);
        check({tag, ".pc"}, pc_o, pc);
        check({tag, ".branch"}, 32'(branch_o), 32'(v.br));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{ADD,          32'h0000_1234, 32'h0,         32'h0,         1'b0, 0, 0, 32'h0000_1234, 4'b0000, 32'h0};
        tbl[1]  = '{32'h0000_8103, 32'h0000_1003, 32'h0,         32'h80FF_0000, 1'b0, 2, 1, 32'hFFFF_FF80, 4'b1000, 32'h0};
        tbl[2]  = '{32'h0000_C103, 32'h0000_1003, 32'h0,         32'h80FF_0000, 1'b0, 2, 1, 32'h0000_0080, 4'b1000, 32'h0};
        tbl[3]  = '{32'h0020_9023, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0,         1'b0, 1, 1, 32'h0000_2002, 4'b1100, 32'hBEEF_BEEF};
        tbl[4]  = '{32'h0000_9103, 32'h0000_3002, 32'h0,         32'h8001_1234, 1'b0, 0, 2, 32'hFFFF_8001, 4'b1100, 32'h0};
        tbl[5]  = '{32'h0000_D103, 32'h0000_3000, 32'h0,         32'h8001_F234, 1'b1, 1, 1, 32'h0000_F234, 4'b0011, 32'h0};
        tbl[6]  = '{LW,           32'h0000_4001, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 3, 32'hDEAD_BEEF, 4'b1111, 32'h0};
        tbl[7]  = '{32'h0020_8023, 32'h0000_5001, 32'h1234_56A5, 32'h0,         1'b0, 0, 1, 32'h0000_5001, 4'b0010, 32'hA5A5_A5A5};
        tbl[8]  = '{32'h0020_A023, 32'h0000_6003, 32'hCAFE_F00D, 32'h0,         1'b1, 2, 1, 32'h0000_6003, 4'b1111, 32'hCAFE_F00D};
        tbl[9]  = '{32'h0000_8103, 32'h0000_7001, 32'h0,         32'h0000_7F00, 1'b0, 0, 1, 32'h0000_007F, 4'b0010, 32'h0};
        tbl[10] = '{32'h0020_9023, 32'h0000_2001, 32'h0000_1357, 32'h0,         1'b0, 0, 1, 32'h0000_2001, 4'b0011, 32'h1357_1357};
        tbl[11] = '{32'h0000_0063, 32'h0000_0080, 32'h0,         32'h0,         1'b1, 0, 0, 32'h0000_0080, 4'b0000, 32'h0};

        rstn_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; valid_i = 1'b0; ack_i = 1'b0;
        instr_i = 32'd0; pc_i = 32'd0; result_i = 32'd0; rs2_i = 32'd0; branch_i = 1'b0;
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'd0; ld_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.data", data_o, 32'd0);
        check("rst.instr", instr_o, 32'd0);
        check("rst.pc", pc_o, 32'd0);
        check("rst.branch", 32'(branch_o), 32'd0);
        check("rst.req", 32'(dmem_bus.req), 32'd0);
        rstn_i = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], 32'h100 + 32'(i) * 32'd4, $sformatf("tbl%0d", i));
        for (int i = 0; i < 40; i++) run_vec(make_rand(), $urandom & 32'hFFFF_FFFC, $sformatf("rnd%0d", i));

        // load completes while WB holds its output
        @(negedge clk);
        ack_i = 1'b0; valid_i = 1'b1; instr_i = LW; result_i = 32'h0000_8000; pc_i = 32'h200;
        #1 check("stall.acc", 32'(ack_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0; dmem_bus.gnt = 1'b1;
        @(negedge clk);
        dmem_bus.gnt = 1'b0; ld_busy = 1'b1; dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem_bus.rvalid = 1'b0; ld_busy = 1'b0;
        @(negedge clk);
        check("stall.load_valid", 32'(valid_o), 32'd1);
        check("stall.load_data", data_o, 32'h1357_9BDF);
        valid_i = 1'b1; instr_i = ADD; result_i = 32'h0000_0055;
        for (int k = 0; k < 2; k++) begin
            #1 check("stall.ack_blocked", 32'(ack_o), 32'd0);
            @(negedge clk);
            check("stall.hold_data", data_o, 32'h1357_9BDF);
        end
        ack_i = 1'b1;
        #1 check("stall.ack_release", 32'(ack_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        check("stall.next_data", data_o, 32'h0000_0055);

        // flush while waiting for load data
        @(negedge clk);
        valid_i = 1'b1; instr_i = LW; result_i = 32'h0000_B004; ack_i = 1'b1;
        #1 check("flw.acc", 32'(ack_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0; dmem_bus.gnt = 1'b1;
        @(negedge clk);
        dmem_bus.gnt = 1'b0; ld_busy = 1'b1; flush_i = 1'b1;
        #1 check("flw.valid_flush", 32'(valid_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b1; instr_i = ADD; result_i = 32'h0000_4242;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            dmem_bus.rvalid = (k == 2);
            dmem_bus.rdata  = 32'hFFFF_FFFF;
            #1 check("flw.ack_wait", 32'(ack_o), 32'd0);
            check("flw.valid_wait", 32'(valid_o), 32'd0);
        end
        @(negedge clk);
        dmem_bus.rvalid = 1'b0; ld_busy = 1'b0;
        #1 check("flw.ack_idle", 32'(ack_o), 32'd1);
        check("flw.no_write", 32'(valid_o), 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        check("flw.next_data", data_o, 32'h0000_4242);

        // flush in REQ without grant
        @(negedge clk);
        valid_i = 1'b1; instr_i = LW; result_i = 32'h0000_A000;
        #1 check("flr.acc", 32'(ack_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        check("flr.req", 32'(dmem_bus.req), 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flr.req_drop", 32'(dmem_bus.req), 32'd0);
        valid_i = 1'b1; instr_i = ADD; result_i = 32'h0000_0099;
        #1 check("flr.idle_acc", 32'(ack_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        check("flr.next_data", data_o, 32'h0000_0099);

        // asynchronous reset in REQ
        @(negedge clk);
        valid_i = 1'b1; instr_i = LW; result_i = 32'h0000_9000;
        #1 check("rreq.acc", 32'(ack_o), 32'd1);
        @(negedge clk);
        check("rreq.req", 32'(dmem_bus.req), 32'd1);
        #2 rstn_i = 1'b0;
        #1 check("rreq.req0", 32'(dmem_bus.req), 32'd0);
        check("rreq.valid0", 32'(valid_o), 32'd0);
        check("rreq.ack0", 32'(ack_o), 32'd0);
        @(negedge clk);
        valid_i = 1'b0; rstn_i = 1'b1;
        run_vec(tbl[6], 32'h300, "rreq.lw");

        // halt freezes the output register
        @(negedge clk);
        ack_i = 1'b0; valid_i = 1'b1; instr_i = ADD; result_i = 32'h0000_0077;
        #1 check("halt.acc", 32'(ack_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0; halt_i = 1'b1; ack_i = 1'b1;
        check("halt.valid", 32'(valid_o), 32'd1);
        @(negedge clk);
        check("halt.hold_valid", 32'(valid_o), 32'd1);
        check("halt.hold_data", data_o, 32'h0000_0077);
        halt_i = 1'b0;
        @(negedge clk);
        check("halt.release", 32'(valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
